accel_sample_packer: RTL
========================

# accel_sample_packer

Byte-to-sample packer directly downstream of the SPI master. Consumes the parallelised MISO bytes and their one-cycle write strobe, strips the command/address header bytes of each chip-select frame, and assembles the following six data bytes into signed 16-bit X/Y/Z samples. Presents one sample at a time on a valid/ready handshake toward the sample FIFO/consumer and flags dropped or truncated frames.

## Interface
- `HDR_BYTES`, 2: bytes discarded at the start of each frame (command + register address); legal range 0..7.
- `LSB_FIRST`, 1: 1 = low byte arrives first per axis; 0 = high byte first.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `frame_start`  in  1  one-cycle pulse when CS asserts (goes low).
- `frame_end`  in  1  one-cycle pulse when CS deasserts (goes high).
- `byte_in`  in  8  received MISO byte; sampled only when `byte_valid`=1.
- `byte_valid`  in  1  one-cycle strobe, one per received byte.
- `sample_x`, `sample_y`, `sample_z`  out  16 each  signed axis values of the held sample.
- `sample_valid`  out  1  held sample available.
- `sample_ready`  in  1  consumer accepts; transfer when `sample_valid`&&`sample_ready`.
- `overflow`  out  1  sticky: a complete sample was dropped because the output was full.
- `short_frame`  out  1  sticky: a frame ended with 1..5 data bytes collected.
- `clear_flags`  in  1  one-cycle pulse clearing `overflow` and `short_frame`.

## Operation
- States: IDLE, SKIP_HDR, COLLECT.
- IDLE: bytes ignored. `frame_start` -> SKIP_HDR (HDR_BYTES>0) or COLLECT (HDR_BYTES=0); `hdr_cnt`, `byte_cnt` cleared.
- SKIP_HDR: each `byte_valid` increments `hdr_cnt`; when it reaches HDR_BYTES -> COLLECT. Header bytes never touch the shadow registers.
- COLLECT: byte k (0..5) written to shadow byte k; axis = k/2 (X, Y, Z); low/high half chosen by k[0] and `LSB_FIRST`. On byte 5: commit shadow to output, `byte_cnt` wraps to 0, stay in COLLECT (burst read of consecutive samples within one frame supported).
- Commit: if `sample_valid`=0, or `sample_ready`=1 in the same cycle, output registers load and `sample_valid`=1. Otherwise the new sample is discarded, output unchanged, `overflow` set.
- `frame_end` in any state -> IDLE. If in COLLECT with `byte_cnt` in 1..5, set `short_frame` and discard partial shadow data. A held output sample is unaffected.
- `frame_start` during SKIP_HDR/COLLECT restarts the frame (counters cleared, partial data discarded, no `short_frame`).
- Same cycle `frame_start` and `byte_valid`: the byte counts as byte 0 of the new frame.
- Same cycle `frame_end` and `byte_valid`: the byte is processed first, then IDLE. A sixth byte therefore still commits.
- Same cycle `frame_start` and `frame_end`: `frame_end` applied first, then `frame_start`.
- `clear_flags` coincident with a new flag event: the set wins.
- No arithmetic: bytes concatenated into 16 bits as received, with no sign extension (the sensor supplies sign-extended high bytes).

## Timing
- Reset values: state IDLE, counters 0, `sample_valid`=0, `sample_x/y/z`=0, `overflow`=0, `short_frame`=0.
- Latency: `sample_valid` rises on the cycle after the `byte_valid` carrying data byte 5.
- `sample_valid` falls on the cycle after a handshake unless a commit coincides, in which case it stays 1 with new data.
- Output data stable while `sample_valid`=1 and `sample_ready`=0.
- Back-to-back `byte_valid` on consecutive cycles supported; no input backpressure exists.
- Reset mid-frame: everything returns to reset values immediately; the next byte is accepted only after `frame_start`.

## Structure
- Shared package `accel_pkg`: state enum (IDLE/SKIP_HDR/COLLECT), `AXIS_BYTES`=2, `SAMPLE_BYTES`=6, axis index constants.
- Single module; no sub-module needed. The shadow bank is a 6×8 register array indexed by `byte_cnt`.

## Test plan
- HDR_BYTES=2, LSB_FIRST=1; frame 0x0B,0x0E,0x34,0x12,0xFE,0xFF,0x00,0x08, then `frame_end` -> x=0x1234, y=0xFFFE, z=0x0800, `sample_valid` one cycle after the last byte.
- Burst of 14 bytes (2 header + 12 data) with `sample_ready` held 1 -> two samples emitted in order, no flags.
- Two samples in one frame with `sample_ready`=0 -> first sample held unchanged, `overflow`=1; `clear_flags` -> `overflow`=0.
- Frame with header + 3 data bytes, then `frame_end` -> `short_frame`=1, `sample_valid` stays 0; the next full frame packs correctly from byte 0.
- `frame_start` coincident with the first header byte, and `frame_end` coincident with data byte 5 -> the sample still commits.
- Assert `rst_n`=0 after 3 data bytes -> all outputs return to 0; a new frame after release produces a correct sample.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer sample packer.
// Covers the FSM state encoding, frame geometry and the byte-pair packing helper.
package accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SKIP_HDR = 2'd1,
    ST_COLLECT  = 2'd2
  } state_t;

  localparam int AXIS_BYTES   = 2;
  localparam int SAMPLE_BYTES = 6;
  localparam int AXIS_X       = 0;
  localparam int AXIS_Y       = 1;
  localparam int AXIS_Z       = 2;

  // Concatenate two received bytes of one axis; no sign extension, the sensor supplies it.
  function automatic logic [15:0] pack_axis(input logic lsb_first,
                                            input logic [7:0] first_b,
                                            input logic [7:0] second_b);
    logic [15:0] v;
    if (lsb_first) begin
      v = {second_b, first_b};
    end else begin
      v = {first_b, second_b};
    end
    return v;
  endfunction

endpackage

// File: rtl/accel_sample_packer.sv
// Strips per-frame header bytes from the SPI byte stream and packs six data bytes
// into an X/Y/Z sample presented on a valid/ready handshake, with sticky error flags.
module accel_sample_packer
  import accel_pkg::*;
#(
  parameter int HDR_BYTES = 2,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [15:0] sample_x,
  output logic [15:0] sample_y,
  output logic [15:0] sample_z,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overflow,
  output logic        short_frame,
  input  logic        clear_flags
);

  localparam logic [2:0] HDR_CNT  = 3'(HDR_BYTES);
  localparam logic [2:0] LAST_IDX = 3'(SAMPLE_BYTES - 1);

  state_t      r_state;
  logic [2:0]  r_hdr_cnt;
  logic [2:0]  r_byte_cnt;
  logic [7:0]  r_shadow [SAMPLE_BYTES];
  logic [15:0] r_sample_x;
  logic [15:0] r_sample_y;
  logic [15:0] r_sample_z;
  logic        r_sample_valid;
  logic        r_overflow;
  logic        r_short_frame;

  state_t      w_state;
  logic [2:0]  w_hdr_cnt;
  logic [2:0]  w_byte_cnt;
  logic [2:0]  w_wr_idx;
  logic        w_wr;
  logic        w_commit;
  logic        w_short_set;
  logic        w_accept;
  logic        w_ovf_set;

  // Event ordering within a cycle: frame_end-before-frame_start, then the byte, then a lone frame_end.
  always_comb begin
    w_state     = r_state;
    w_hdr_cnt   = r_hdr_cnt;
    w_byte_cnt  = r_byte_cnt;
    w_wr_idx    = r_byte_cnt;
    w_wr        = 1'b0;
    w_commit    = 1'b0;
    w_short_set = 1'b0;
    if (frame_start) begin
      w_short_set = frame_end && (r_state == ST_COLLECT) && (r_byte_cnt != 3'd0);
      w_state     = (HDR_BYTES > 0) ? ST_SKIP_HDR : ST_COLLECT;
      w_hdr_cnt   = 3'd0;
      w_byte_cnt  = 3'd0;
    end else begin
      w_short_set = 1'b0;
    end
    if (byte_valid) begin
      case (w_state)
        ST_SKIP_HDR: begin
          w_hdr_cnt = w_hdr_cnt + 3'd1;
          if (w_hdr_cnt == HDR_CNT) begin
            w_state = ST_COLLECT;
          end else begin
            w_state = ST_SKIP_HDR;
          end
        end
        ST_COLLECT: begin
          w_wr     = 1'b1;
          w_wr_idx = w_byte_cnt;
          if (w_byte_cnt == LAST_IDX) begin
            w_commit   = 1'b1;
            w_byte_cnt = 3'd0;
          end else begin
            w_byte_cnt = w_byte_cnt + 3'd1;
          end
        end
        default: w_wr = 1'b0;
      endcase
    end else begin
      w_wr = 1'b0;
    end
    if (frame_end && !frame_start) begin
      w_short_set = (w_state == ST_COLLECT) && (w_byte_cnt != 3'd0);
      w_state     = ST_IDLE;
      w_hdr_cnt   = 3'd0;
      w_byte_cnt  = 3'd0;
    end else begin
      w_state = w_state;
    end
  end

  assign w_accept  = w_commit && (!r_sample_valid || sample_ready);
  assign w_ovf_set = w_commit && r_sample_valid && !sample_ready;

  // Frame state, counters and the shadow byte bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_hdr_cnt  <= 3'd0;
      r_byte_cnt <= 3'd0;
      for (int i = 0; i < SAMPLE_BYTES; i++) begin
        r_shadow[i] <= 8'd0;
      end
    end else begin
      r_state    <= w_state;
      r_hdr_cnt  <= w_hdr_cnt;
      r_byte_cnt <= w_byte_cnt;
      if (w_wr) begin
        r_shadow[w_wr_idx] <= byte_in;
      end else begin
        r_shadow[w_wr_idx] <= r_shadow[w_wr_idx];
      end
    end
  end

  // Output holding register and sticky flags; a flag set beats a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_x     <= 16'd0;
      r_sample_y     <= 16'd0;
      r_sample_z     <= 16'd0;
      r_sample_valid <= 1'b0;
      r_overflow     <= 1'b0;
      r_short_frame  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sample_x     <= pack_axis(LSB_FIRST, r_shadow[AXIS_X*AXIS_BYTES], r_shadow[AXIS_X*AXIS_BYTES+1]);
        r_sample_y     <= pack_axis(LSB_FIRST, r_shadow[AXIS_Y*AXIS_BYTES], r_shadow[AXIS_Y*AXIS_BYTES+1]);
        r_sample_z     <= pack_axis(LSB_FIRST, r_shadow[AXIS_Z*AXIS_BYTES], byte_in);
        r_sample_valid <= 1'b1;
      end else if (r_sample_valid && sample_ready) begin
        r_sample_valid <= 1'b0;
      end else begin
        r_sample_valid <= r_sample_valid;
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clear_flags) begin
        r_overflow <= 1'b0;
      end else begin
        r_overflow <= r_overflow;
      end
      if (w_short_set) begin
        r_short_frame <= 1'b1;
      end else if (clear_flags) begin
        r_short_frame <= 1'b0;
      end else begin
        r_short_frame <= r_short_frame;
      end
    end
  end

  assign sample_x     = r_sample_x;
  assign sample_y     = r_sample_y;
  assign sample_z     = r_sample_z;
  assign sample_valid = r_sample_valid;
  assign overflow     = r_overflow;
  assign short_frame  = r_short_frame;

endmodule
